// File: rtl/lvds_pll_dps_pkg.sv
// Shared state encoding and PLL counter-select constants for the LVDS PLL
// dynamic-phase-shift controller.
package lvds_pll_dps_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    WAIT_LOW,
    WAIT_HIGH,
    GAP,
    FINISH
  } dps_state_e;

  // The two LVDS PLL output counters that bit alignment steps.
  localparam logic [4:0] CNTSEL_C0 = 5'd0;
  localparam logic [4:0] CNTSEL_C1 = 5'd1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lvds_pll_dps_sync.sv
// Generic 2-flop synchroniser; every bit is treated as an independent
// asynchronous level and resets to 0.
module lvds_pll_dps_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        meta_q <= 1'b0;
        sync_q <= 1'b0;
      end else begin
        meta_q <= d_i[gi];
        sync_q <= meta_q;
      end
    end

    assign q_o[gi] = sync_q;
  end

endmodule

// File: rtl/lvds_pll_dps_ctrl.sv
// Sequencer for the LVDS receiver PLL dynamic-phase-shift port: one
// phase_en/phase_done handshake per step. Optional per-step watchdog: LVDS_PLL_DPS_TIMEOUT_EN.
module lvds_pll_dps_ctrl
  import lvds_pll_dps_pkg::*;
#(
  parameter int STEP_W      = 8,
  parameter int PULSE_CYC   = 2,
  parameter int GAP_CYC     = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              scanclk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_updn_i,
  input  logic [4:0]        cmd_cntsel_i,
  input  logic [STEP_W-1:0] cmd_steps_i,
  input  logic              locked_i,
  input  logic              phase_done_i,
  output logic              phase_en_o,
  output logic              updn_o,
  output logic [4:0]        cntsel_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [STEP_W-1:0] steps_done_o
);

  localparam int CNT_W = $clog2(max_int(PULSE_CYC, GAP_CYC) + 1);

  if (PULSE_CYC < 2 || GAP_CYC < 1 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("lvds_pll_dps_ctrl: needs PULSE_CYC>=2, GAP_CYC>=1, TIMEOUT_CYC>=1");
  end

  logic locked_s;
  logic done_s;

  lvds_pll_dps_sync #(.WIDTH(1)) u_sync_locked (
    .clk_i (scanclk_i),
    .rst_i (rst_i),
    .d_i   (locked_i),
    .q_o   (locked_s)
  );

  lvds_pll_dps_sync #(.WIDTH(1)) u_sync_done (
    .clk_i (scanclk_i),
    .rst_i (rst_i),
    .d_i   (phase_done_i),
    .q_o   (done_s)
  );

  dps_state_e        state_q;
  logic              phase_en_q;
  logic              updn_q;
  logic [4:0]        cntsel_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [STEP_W-1:0] steps_q;
  logic [STEP_W-1:0] steps_done_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              low_seen_q;

  logic in_step;
  logic wd_expired;
  logic abort;

  // FINISH is excluded so a persistent lock loss cannot hold the FSM there.
  assign in_step = (state_q != IDLE) && (state_q != FINISH);

`ifdef LVDS_PLL_DPS_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic            in_wait;
  logic [WD_W-1:0] wdog_q;

  assign in_wait = (state_q == WAIT_LOW) || (state_q == WAIT_HIGH);

  // Reloaded as the FSM enters PULSE; only the two wait states consume it.
  always_ff @(posedge scanclk_i) begin
    if (rst_i || state_q == SETUP) begin
      wdog_q <= WD_W'(TIMEOUT_CYC);
    end else if (in_wait && wdog_q != '0) begin
      wdog_q <= wdog_q - WD_W'(1);
    end
  end

  assign wd_expired = in_wait && (wdog_q == '0);
`else
  assign wd_expired = 1'b0;
`endif

  assign abort = in_step && (!locked_s || wd_expired);

  always_ff @(posedge scanclk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      phase_en_q   <= 1'b0;
      updn_q       <= 1'b0;
      cntsel_q     <= CNTSEL_C0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      steps_q      <= '0;
      steps_done_q <= '0;
      cnt_q        <= '0;
      low_seen_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        // The step in flight is dropped without touching steps_done.
        phase_en_q <= 1'b0;
        err_q      <= 1'b1;
        done_q     <= 1'b1;
        state_q    <= FINISH;
      end else begin
        case (state_q)
          IDLE: begin
            if (cmd_valid_i && cmd_ready_o) begin
              updn_q       <= cmd_updn_i;
              cntsel_q     <= cmd_cntsel_i;
              steps_q      <= cmd_steps_i;
              err_q        <= 1'b0;
              steps_done_q <= '0;
              if (cmd_steps_i == '0) begin
                done_q <= 1'b1;
              end else begin
                busy_q  <= 1'b1;
                state_q <= SETUP;
              end
            end
          end

          SETUP: begin
            phase_en_q <= 1'b1;
            cnt_q      <= CNT_W'(PULSE_CYC - 1);
            low_seen_q <= 1'b0;
            state_q    <= PULSE;
          end

          PULSE: begin
            if (!done_s) begin
              low_seen_q <= 1'b1;
            end
            if (cnt_q == '0) begin
              phase_en_q <= 1'b0;
              state_q    <= (low_seen_q || !done_s) ? WAIT_HIGH : WAIT_LOW;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end

          WAIT_LOW: begin
            if (!done_s) begin
              state_q <= WAIT_HIGH;
            end
          end

          WAIT_HIGH: begin
            if (done_s) begin
              if (steps_done_q != steps_q) begin
                steps_done_q <= steps_done_q + STEP_W'(1);
              end
              cnt_q   <= CNT_W'(GAP_CYC - 1);
              state_q <= GAP;
            end
          end

          GAP: begin
            if (cnt_q == '0) begin
              if (steps_done_q < steps_q) begin
                state_q <= SETUP;
              end else begin
                done_q  <= 1'b1;
                state_q <= FINISH;
              end
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end

          FINISH: begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end

          default: begin
            phase_en_q <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end
        endcase
      end
    end
  end

  assign cmd_ready_o  = (state_q == IDLE) && locked_s;
  assign phase_en_o   = phase_en_q;
  assign updn_o       = updn_q;
  assign cntsel_o     = cntsel_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign steps_done_o = steps_done_q;

endmodule

// File: tb/tb_lvds_pll_dps_ctrl.sv
// Self-checking bench for lvds_pll_dps_ctrl with a behavioural PLL DPS model;
// the watchdog case follows LVDS_PLL_DPS_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_lvds_pll_dps_ctrl;
  import lvds_pll_dps_pkg::*;

  localparam int STEP_W      = 8;
  localparam int PULSE_CYC   = 2;
  localparam int GAP_CYC     = 4;
  localparam int TIMEOUT_CYC = 16;

  logic              clk        = 1'b0;
  logic              rst        = 1'b1;
  logic              cmd_valid  = 1'b0;
  logic              cmd_updn   = 1'b0;
  logic [4:0]        cmd_cntsel = 5'd0;
  logic [STEP_W-1:0] cmd_steps  = '0;
  logic              locked     = 1'b0;
  logic              phase_done = 1'b1;
  logic              cmd_ready, phase_en, updn, busy, done, err;
  logic [4:0]        cntsel;
  logic [STEP_W-1:0] steps_done;

  lvds_pll_dps_ctrl #(
    .STEP_W(STEP_W), .PULSE_CYC(PULSE_CYC), .GAP_CYC(GAP_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .scanclk_i    (clk),
    .rst_i        (rst),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_updn_i   (cmd_updn),
    .cmd_cntsel_i (cmd_cntsel),
    .cmd_steps_i  (cmd_steps),
    .locked_i     (locked),
    .phase_done_i (phase_done),
    .phase_en_o   (phase_en),
    .updn_o       (updn),
    .cntsel_o     (cntsel),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .steps_done_o (steps_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // PLL DPS model: phase_done falls 3 cycles after a phase_en rise, returns 5 later.
  bit   pll_mute = 1'b0;
  logic pe_m     = 1'b0;
  int   pll_cnt  = 0;
  int   pll_nxt;
  always @(negedge clk) begin
    pe_m <= phase_en;
    if (rst) begin
      pll_cnt    <= 0;
      phase_done <= 1'b1;
    end else begin
      pll_nxt = 0;
      if (phase_en && !pe_m) pll_nxt = 1;
      else if (pll_cnt != 0 && pll_cnt < 8) pll_nxt = pll_cnt + 1;
      pll_cnt <= pll_nxt;
      if (pll_nxt == 3) phase_done <= 1'b0;
      if (pll_nxt == 8 && !pll_mute) phase_done <= 1'b1;
    end
  end

  // Cumulative observations of the PLL-facing outputs.
  logic       exp_updn   = 1'b0;
  logic [4:0] exp_cntsel = 5'd0;
  logic pe_prev = 1'b0, done_prev = 1'b0, busy_prev = 1'b0;
  int   m_pulses = 0, m_wbad = 0, m_gbad = 0, m_attr_bad = 0, m_dones = 0, m_busy_rises = 0;
  int   width = 0, low_run = 0;
  bit   seen_fall = 1'b0;
  always @(negedge clk) begin
    pe_prev   <= phase_en;
    done_prev <= done;
    busy_prev <= busy;
    if (phase_en && !pe_prev) begin
      m_pulses <= m_pulses + 1;
      width    <= 1;
      if (seen_fall && low_run < GAP_CYC) m_gbad <= m_gbad + 1;
    end else if (phase_en) begin
      width <= width + 1;
    end else if (pe_prev) begin
      if (width != PULSE_CYC) m_wbad <= m_wbad + 1;
      low_run   <= 1;
      seen_fall <= 1'b1;
    end else begin
      low_run <= low_run + 1;
    end
    if (phase_en && (updn !== exp_updn || cntsel !== exp_cntsel)) m_attr_bad <= m_attr_bad + 1;
    if (done && !done_prev) m_dones <= m_dones + 1;
    if (busy && !busy_prev) m_busy_rises <= m_busy_rises + 1;
  end

  typedef struct {
    logic [STEP_W-1:0] steps;
    logic              updn;
    logic [4:0]        cntsel;
    int                exp_pulses;
    logic [STEP_W-1:0] exp_sd;
    logic              exp_err;
    int                exp_lat;   // 0 = latency not checked
  } vec_t;
  vec_t vecs [5];

  int s_pulses, s_wbad, s_gbad, s_attr, s_dones, s_busy;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic start_cmd(input logic [STEP_W-1:0] st, input logic ud, input logic [4:0] cs);
    bit ok = 1'b0;
    exp_updn   = ud;
    exp_cntsel = cs;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("cmd_ready_wait", 0, 1);
    s_pulses = m_pulses; s_wbad = m_wbad; s_gbad = m_gbad;
    s_attr = m_attr_bad; s_dones = m_dones; s_busy = m_busy_rises;
    cmd_valid = 1'b1; cmd_steps = st; cmd_updn = ud; cmd_cntsel = cs;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int lat);
    lat = 0;
    for (int i = 1; i <= limit; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
    if (lat == 0) check("done_wait", 0, 1);
  endtask

  task automatic end_checks(input string name, input int ep, input logic [STEP_W-1:0] esd,
                            input logic eerr, input int lat);
    check({name, "_steps_done"}, steps_done, esd);
    check({name, "_err"}, err, eerr);
    check({name, "_phase_en_at_done"}, phase_en, 0);
    @(negedge clk);
    check({name, "_done_one_cycle"}, done, 0);
    check({name, "_busy_after"}, busy, 0);
    check({name, "_pulses"}, m_pulses - s_pulses, ep);
    check({name, "_bad_widths"}, m_wbad - s_wbad, 0);
    check({name, "_short_gaps"}, m_gbad - s_gbad, 0);
    check({name, "_updn_cntsel_unstable"}, m_attr_bad - s_attr, 0);
    check({name, "_done_pulses"}, m_dones - s_dones, 1);
    check({name, "_busy_rises"}, m_busy_rises - s_busy, (ep > 0) ? 1 : 0);
    $display("[TB] %s: pulses=%0d steps_done=%0d err=%0d lat=%0d", name,
             m_pulses - s_pulses, steps_done, err, lat);
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int lat;
    start_cmd(v.steps, v.updn, v.cntsel);
    wait_done(3000, lat);
    if (v.exp_lat != 0) check({name, "_latency"}, lat, v.exp_lat);
    end_checks(name, v.exp_pulses, v.exp_sd, v.exp_err, lat);
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {phase_en, updn, cntsel, busy, done, err, steps_done, cmd_ready}, 0);
  endtask

  initial begin
    int lat, rises, busy_low;
    logic prev;
    vec_t rv;

    vecs[0] = '{8'd3, 1'b1, CNTSEL_C1, 3, 8'd3, 1'b0, 0};
    vecs[1] = '{8'd0, 1'b0, CNTSEL_C0, 0, 8'd0, 1'b0, 1};
    vecs[2] = '{8'd1, 1'b0, CNTSEL_C0, 1, 8'd1, 1'b0, 0};
    vecs[3] = '{8'd4, 1'b1, 5'd17,     4, 8'd4, 1'b0, 0};
    vecs[4] = '{8'd0, 1'b1, 5'd9,      0, 8'd0, 1'b0, 1};

    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    rst = 1'b0;
    locked = 1'b1;

    for (int k = 0; k < 5; k++) run_vec($sformatf("vec%0d", k), vecs[k]);

    // Randomised commands against the step-count model.
    for (int k = 0; k < 6; k++) begin
      rv.steps      = STEP_W'($urandom_range(0, 5));
      rv.updn       = 1'($urandom_range(0, 1));
      rv.cntsel     = 5'($urandom_range(0, 31));
      rv.exp_pulses = int'(rv.steps);
      rv.exp_sd     = rv.steps;
      rv.exp_err    = 1'b0;
      rv.exp_lat    = (rv.steps == 0) ? 1 : 0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_vec($sformatf("rand%0d", k), rv);
    end

    // Lock lost in the second WAIT_HIGH of a 5-step command.
    start_cmd(8'd5, 1'b0, CNTSEL_C0);
    rises = 0;
    prev  = phase_en;
    for (int i = 0; i < 400 && rises < 2; i++) begin
      @(negedge clk);
      if (phase_en && !prev) rises++;
      prev = phase_en;
    end
    for (int i = 0; i < 50 && phase_done; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    locked = 1'b0;
    wait_done(100, lat);
    end_checks("lock_loss", 2, 8'd1, 1'b1, lat);
    repeat (3) @(negedge clk);
    check("lock_loss_ready_low", cmd_ready, 0);
    locked = 1'b1;
    run_vec("err_clear_noop", vecs[1]);

    // PLL never returns phase_done.
    pll_mute = 1'b1;
    start_cmd(8'd1, 1'b1, CNTSEL_C1);
    for (int i = 0; i < 50 && !phase_en; i++) @(negedge clk);
    for (int i = 0; i < 50 && phase_en; i++) @(negedge clk);
`ifdef LVDS_PLL_DPS_TIMEOUT_EN
    wait_done(80, lat);
    check("wdog_latency_window", (lat >= TIMEOUT_CYC && lat <= TIMEOUT_CYC + 6), 1);
    end_checks("watchdog", 1, 8'd0, 1'b1, lat);
`else
    busy_low = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) busy_low++;
    end
    check("stall_busy_held", busy_low, 0);
    check("stall_no_done", m_dones - s_dones, 0);
`endif
    pll_mute = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("stall_reset");
    rst = 1'b0;

    // Command offered while busy must be ignored.
    start_cmd(8'd3, 1'b1, CNTSEL_C1);
    busy_low = 0;
    for (int i = 0; i < 10; i++) begin
      cmd_valid = 1'b1; cmd_cntsel = 5'd7; cmd_updn = 1'b0; cmd_steps = 8'd9;
      @(negedge clk);
      if (!busy) busy_low++;
    end
    cmd_valid = 1'b0;
    check("busy_ignore_busy_held", busy_low, 0);
    wait_done(3000, lat);
    end_checks("busy_ignore", 3, 8'd3, 1'b0, lat);
    check("busy_ignore_cntsel", cntsel, CNTSEL_C1);
    check("busy_ignore_updn", updn, 1);

    // Reset while phase_en is high.
    start_cmd(8'd3, 1'b1, CNTSEL_C1);
    for (int i = 0; i < 50 && !phase_en; i++) @(negedge clk);
    check("pulse_reached", phase_en, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_in_pulse");
    rst = 1'b0;
    run_vec("after_rst", '{8'd2, 1'b0, CNTSEL_C0, 2, 8'd2, 1'b0, 0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL global_timeout: simulation did not complete, failed so far %0d", n_fail);
    $fatal(1);
  end

endmodule
